// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared sizes and FSM encoding for the issue stage
package issue_ctrl_pkg;

  localparam int NB_UNIT      = 6;
  localparam int NB_WB        = 2;
  localparam int MAX_INFLIGHT = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SER   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// rtl/issue_ctrl_scoreboard.sv - per-register pending-write tracking and RAW/WAW detection
module issue_ctrl_scoreboard #(
  parameter int NB_WB = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush_i,
  input  logic               set_v_i,
  input  logic [4:0]         set_rd_i,
  input  logic [NB_WB-1:0]   wb_v_i,
  input  logic [NB_WB*5-1:0] wb_rd_i,
  input  logic               rs1_v_i,
  input  logic [4:0]         rs1_i,
  input  logic               rs2_v_i,
  input  logic [4:0]         rs2_i,
  input  logic               rd_v_i,
  input  logic [4:0]         rd_i,
  output logic               raw_o,
  output logic               waw_o,
  output logic [31:0]        busy_o
);

  logic [31:1] busy_q, busy_d;
  logic [31:0] clr_mask;
  logic [31:0] busy_eff;

  // Writebacks bypass into the hazard check; an issue to the same register wins.
  always_comb begin
    clr_mask = '0;
    for (int k = 0; k < NB_WB; k++) begin
      if (wb_v_i[k]) clr_mask[wb_rd_i[5*k +: 5]] = 1'b1;
    end
    busy_eff = {busy_q, 1'b0} & ~clr_mask;
    busy_d   = busy_q;
    for (int r = 1; r < 32; r++) begin
      busy_d[r] = busy_eff[r] | (set_v_i && (set_rd_i == 5'(r)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else if (flush_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign raw_o  = (rs1_v_i & busy_eff[rs1_i]) | (rs2_v_i & busy_eff[rs2_i]);
  assign waw_o  = rd_v_i & busy_eff[rd_i];
  assign busy_o = {busy_q, 1'b0};

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order single-issue control: hazards, in-flight count, serialize drain
module issue_ctrl #(
  parameter int  NB_UNIT      = issue_ctrl_pkg::NB_UNIT,
  parameter int  NB_WB        = issue_ctrl_pkg::NB_WB,
  parameter int  MAX_INFLIGHT = issue_ctrl_pkg::MAX_INFLIGHT,
  localparam int INFL_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush_i,
  input  logic               dec_valid_i,
  output logic               dec_ready_o,
  input  logic               dec_rd_v_i,
  input  logic [4:0]         dec_rd_i,
  input  logic               dec_rs1_v_i,
  input  logic [4:0]         dec_rs1_i,
  input  logic               dec_rs2_v_i,
  input  logic [4:0]         dec_rs2_i,
  input  logic [NB_UNIT-1:0] dec_unit_i,
  input  logic               dec_serialize_i,
  input  logic [NB_UNIT-1:0] unit_ready_i,
  output logic               issue_valid_o,
  output logic [NB_UNIT-1:0] issue_unit_o,
  input  logic [NB_UNIT-1:0] done_i,
  input  logic [NB_WB-1:0]   wb_v_i,
  input  logic [NB_WB*5-1:0] wb_rd_i,
  output logic [31:0]        busy_o,
  output logic [INFL_W-1:0]  inflight_o
);

  import issue_ctrl_pkg::*;

  issue_state_t      state_q, state_d;
  logic [INFL_W-1:0] inflight_q, inflight_d, inflight_nx;
  logic              raw, waw, unit_ok, cap_ok, any_done, ser_gate, can_issue;
  logic              set_v, underflow;
  int                done_cnt, infl_sum;

  issue_ctrl_scoreboard #(.NB_WB(NB_WB)) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush_i  (flush_i),
    .set_v_i  (set_v),
    .set_rd_i (dec_rd_i),
    .wb_v_i   (wb_v_i),
    .wb_rd_i  (wb_rd_i),
    .rs1_v_i  (dec_rs1_v_i),
    .rs1_i    (dec_rs1_i),
    .rs2_v_i  (dec_rs2_v_i),
    .rs2_i    (dec_rs2_i),
    .rd_v_i   (dec_rd_v_i),
    .rd_i     (dec_rd_i),
    .raw_o    (raw),
    .waw_o    (waw),
    .busy_o   (busy_o)
  );

  assign any_done = |done_i;
  assign unit_ok  = |(dec_unit_i & unit_ready_i);
  assign cap_ok   = (int'(inflight_q) < MAX_INFLIGHT) | any_done;
  assign set_v    = can_issue & dec_rd_v_i & (dec_rd_i != 5'd0);

  always_comb begin
    done_cnt = 0;
    for (int u = 0; u < NB_UNIT; u++) done_cnt += int'(done_i[u]);
  end

  // A serializing instruction only leaves RUN directly when the pipe is already empty.
  always_comb begin
    ser_gate = 1'b0;
    if (state_q == RUN) begin
      ser_gate = !dec_serialize_i || ((inflight_q == '0) && !any_done);
    end
    can_issue = reset_n & dec_valid_i & ~flush_i & ~raw & ~waw & unit_ok & cap_ok & ser_gate;
  end

  always_comb begin
    infl_sum    = int'(inflight_q) + int'(can_issue) - done_cnt;
    underflow   = (infl_sum < 0);
    inflight_nx = underflow ? '0 : INFL_W'(infl_sum);

    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dec_valid_i && dec_serialize_i) begin
          if (can_issue) state_d = SER;
          else if (inflight_q != '0) state_d = DRAIN;
        end
      end
      DRAIN, SER: begin
        if (inflight_nx == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    inflight_d = inflight_nx;
    if (flush_i) begin
      state_d    = RUN;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  assign dec_ready_o   = can_issue;
  assign issue_valid_o = can_issue;
  assign issue_unit_o  = dec_unit_i & {NB_UNIT{can_issue}};
  assign inflight_o    = inflight_q;

  // More completions than outstanding operations means a unit misbehaved.
  inflight_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(underflow && !flush_i));

endmodule
